acq_trigger_sequencer: RTL

//  Shares the single waveform-acquisition engine among NREQ requesters (CSR, interlock, PM, test).

---
 rtl/acq_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 43 ++++
 rtl/acq_trigger_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/acq_pkg.sv
// Shared constants for the acquisition trigger sequencer.
// Trigger-mode codes and FSM state encoding.
package acq_pkg;

    localparam logic [1:0] TRIG_IMM = 2'd0;
    localparam logic [1:0] TRIG_FA  = 2'd1;
    localparam logic [1:0] TRIG_SA  = 2'd2;
    localparam logic [1:0] TRIG_EXT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_ARMED,
        ST_CAPTURE,
        ST_DONE
    } acqState_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first request at/after the pointer.
// The pointer moves past the winner only when the grant is accepted.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic [NREQ-1:0] req,
    input  logic            accept,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grantIdx,
    output logic            anyReq
);

    logic [IW-1:0] ptr;
    int            j;

    always_comb begin
        grant    = '0;
        grantIdx = '0;
        anyReq   = 1'b0;
        j        = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!anyReq && req[j]) begin
                anyReq   = 1'b1;
                grant[j] = 1'b1;
                grantIdx = IW'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ptr <= '0;
        end else if (accept && anyReq) begin
            ptr <= (grantIdx == IW'(NREQ - 1)) ? '0 : grantIdx + 1'b1;
        end
    end

endmodule

// File: rtl/acq_trigger_sequencer.sv
// Shares the acquisition engine among NREQ requesters: arbitrate, arm on a
// marker/trigger edge, count captured samples, report done/timeout/abort.
module acq_trigger_sequencer
    import acq_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int COUNT_WIDTH = 24,
    parameter int TMO_WIDTH   = 28
) (
    input  logic                        evrClk,
    input  logic                        evrResetN,
    input  logic [NREQ-1:0]             reqValid,
    input  logic [2*NREQ-1:0]           reqMode,
    input  logic [COUNT_WIDTH*NREQ-1:0] reqCount,
    input  logic [TMO_WIDTH-1:0]        armTimeout,
    input  logic                        abort,
    input  logic                        faMarker,
    input  logic                        saMarker,
    input  logic                        extTrigger,
    input  logic                        sampleValid,
    output logic [NREQ-1:0]             reqGrant,
    output logic [NREQ-1:0]             reqDone,
    output logic                        acqStart,
    output logic                        acqActive,
    output logic                        statusTimeout,
    output logic                        statusAbort
);

    localparam int IW = $clog2(NREQ);

    acqState_t              state;
    acqState_t              stateNext;
    logic                   faD;
    logic                   saD;
    logic                   extD;
    logic [NREQ-1:0]        ownerHot;
    logic [1:0]             mode;
    logic [COUNT_WIDTH-1:0] sampleCnt;
    logic [COUNT_WIDTH-1:0] winCount;
    logic [TMO_WIDTH-1:0]   tmoCnt;
    logic [NREQ-1:0]        arbGrant;
    logic [IW-1:0]          arbIdx;
    logic                   arbAny;
    logic                   trig;
    logic                   timeoutHit;
    logic                   lastSample;
    logic                   sampleTaken;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) uArb (
        .clk      (evrClk),
        .rstN     (evrResetN),
        .req      (reqValid),
        .accept   (state == ST_ARB),
        .grant    (arbGrant),
        .grantIdx (arbIdx),
        .anyReq   (arbAny)
    );

    always_comb begin
        trig = 1'b0;
        unique case (mode)
            TRIG_IMM: trig = 1'b1;
            TRIG_FA:  trig = faMarker & ~faD;
            TRIG_SA:  trig = saMarker & ~saD;
            TRIG_EXT: trig = extTrigger & ~extD;
        endcase
    end

    assign winCount    = reqCount[arbIdx*COUNT_WIDTH +: COUNT_WIDTH];
    assign timeoutHit  = (armTimeout != '0) && (tmoCnt >= armTimeout);
    // The sample arriving alongside acqStart belongs to no capture.
    assign sampleTaken = sampleValid && !acqStart;
    assign lastSample  = sampleTaken && (sampleCnt == COUNT_WIDTH'(1));

    always_comb begin
        stateNext = state;
        unique case (state)
            ST_IDLE:    if (|reqValid) stateNext = ST_ARB;
            ST_ARB:     stateNext = arbAny ? ST_ARMED : ST_IDLE;
            ST_ARMED: begin
                if (abort || (!trig && timeoutHit)) stateNext = ST_DONE;
                else if (trig)                      stateNext = ST_CAPTURE;
            end
            ST_CAPTURE: if (abort || lastSample) stateNext = ST_DONE;
            ST_DONE:    stateNext = ST_IDLE;
            default:    stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge evrClk or negedge evrResetN) begin
        if (!evrResetN) begin
            state         <= ST_IDLE;
            faD           <= 1'b0;
            saD           <= 1'b0;
            extD          <= 1'b0;
            ownerHot      <= '0;
            mode          <= TRIG_IMM;
            sampleCnt     <= '0;
            tmoCnt        <= '0;
            acqStart      <= 1'b0;
            statusTimeout <= 1'b0;
            statusAbort   <= 1'b0;
        end else begin
            state    <= stateNext;
            faD      <= faMarker;
            saD      <= saMarker;
            extD     <= extTrigger;
            acqStart <= 1'b0;
            unique case (state)
                ST_ARB: begin
                    if (arbAny) begin
                        ownerHot      <= arbGrant;
                        mode          <= reqMode[arbIdx*2 +: 2];
                        sampleCnt     <= (winCount == '0) ? COUNT_WIDTH'(1) : winCount;
                        tmoCnt        <= '0;
                        statusTimeout <= 1'b0;
                        statusAbort   <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (abort)           statusAbort   <= 1'b1;
                    else if (trig)       acqStart      <= 1'b1;
                    else if (timeoutHit) statusTimeout <= 1'b1;
                    if (tmoCnt != '1) tmoCnt <= tmoCnt + 1'b1;
                end
                ST_CAPTURE: begin
                    if (abort) statusAbort <= 1'b1;
                    else if (sampleTaken && !lastSample) sampleCnt <= sampleCnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign reqGrant  = (state == ST_ARMED || state == ST_CAPTURE) ? ownerHot : '0;
    assign reqDone   = (state == ST_DONE) ? ownerHot : '0;
    assign acqActive = (state == ST_CAPTURE);

endmodule
